// File: rtl/stall_clk_gate_ctrl.sv
// stall_clk_gate_ctrl: per-channel stall FSMs (RUN/HOLD/TIMED) driving latch-based ICGs.
//   clk, rst (async, active-low)      source clock and reset
//   CLK_EN / CLK_DIS [NUM_CH]         per-channel re-enable / stall requests
//   AUTO_MODE [NUM_CH]                1 = timed stall, 0 = hold stall
//   STALL_LEN [NUM_CH*CNT_W]          timed-stall length, channel i at [i*CNT_W +: CNT_W]
//   FORCE_ON, TEST_EN                 global run override / scan ungate
//   GATED_CLK, STALLED, RESUMED [NUM_CH], ALL_STALLED
module stall_clk_gate_ctrl #(
  parameter int NUM_CH = 9,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       CLK_EN,
  input  logic [NUM_CH-1:0]       CLK_DIS,
  input  logic [NUM_CH-1:0]       AUTO_MODE,
  input  logic [NUM_CH*CNT_W-1:0] STALL_LEN,
  input  logic                    FORCE_ON,
  input  logic                    TEST_EN,
  output logic [NUM_CH-1:0]       GATED_CLK,
  output logic [NUM_CH-1:0]       STALLED,
  output logic [NUM_CH-1:0]       RESUMED,
  output logic                    ALL_STALLED
);
  typedef enum logic [1:0] {RUN, HOLD, TIMED} state_e;
  state_e           st_q  [NUM_CH];
  state_e           st_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, res_q, res_d, en_lat;
  logic all_q;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      en_d[i]  = en_q[i];
      cnt_d[i] = cnt_q[i];
      res_d[i] = 1'b0;
      if (FORCE_ON || CLK_EN[i]) begin
        st_d[i] = RUN;
        en_d[i] = 1'b1;
      end else if (st_q[i] == RUN && CLK_DIS[i]) begin
        if (!AUTO_MODE[i]) begin
          st_d[i] = HOLD;
          en_d[i] = 1'b0;
        end else if (STALL_LEN[i*CNT_W +: CNT_W] != '0) begin
          st_d[i]  = TIMED;
          en_d[i]  = 1'b0;
          cnt_d[i] = STALL_LEN[i*CNT_W +: CNT_W];
        end
      end else if (st_q[i] == TIMED) begin
        // Exit on the count of 1 so the counter never reaches 0 and never wraps.
        if (cnt_q[i] == CNT_W'(1)) begin
          st_d[i]  = RUN;
          en_d[i]  = 1'b1;
          res_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= RUN;
        cnt_q[i] <= '0;
      end
      en_q  <= '1;
      res_q <= '0;
      all_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      en_q  <= en_d;
      res_q <= res_d;
      all_q <= &(~en_d);
    end
  end
  // ICG latch: open only while clk is low, so the enable is stable for the whole high phase.
  // Reset reaches the latch through en_q during the next low phase, avoiding a runt pulse.
  always_latch begin
    if (!clk) en_lat = en_q | {NUM_CH{TEST_EN}};
  end
  assign GATED_CLK   = {NUM_CH{clk}} & en_lat;
  assign STALLED     = ~en_q;
  assign RESUMED     = res_q;
  assign ALL_STALLED = all_q;
endmodule

// File: tb/tb_stall_clk_gate_ctrl.sv
// tb_stall_clk_gate_ctrl: table vectors, directed stall sequences and random stimulus against a reference model.
module tb_stall_clk_gate_ctrl;
  localparam int N = 9;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] CLK_EN = '0, CLK_DIS = '0, AUTO_MODE = '0;
  logic [N*8-1:0] STALL_LEN = '0;
  logic FORCE_ON = 1'b0, TEST_EN = 1'b0;
  logic [N-1:0] GATED_CLK, STALLED, RESUMED;
  logic ALL_STALLED;
  int checks = 0, errors = 0;
  int rem [N];
  int gcnt [N];
  time trise [N];
  logic [N-1:0] gprev;

  stall_clk_gate_ctrl #(.NUM_CH(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .CLK_EN(CLK_EN), .CLK_DIS(CLK_DIS), .AUTO_MODE(AUTO_MODE),
    .STALL_LEN(STALL_LEN), .FORCE_ON(FORCE_ON), .TEST_EN(TEST_EN),
    .GATED_CLK(GATED_CLK), .STALLED(STALLED), .RESUMED(RESUMED), .ALL_STALLED(ALL_STALLED)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // Gated clock edges may only coincide with clk edges (multiples of 5) and high pulses last a full half period.
  always @(GATED_CLK) begin
    for (int i = 0; i < N; i++) begin
      if (GATED_CLK[i] !== gprev[i]) begin
        checks++;
        if ($time % 5 != 0) begin
          errors++;
          $display("FAIL gated_edge_off_clk ch%0d time %0t required multiple of 5", i, $time);
        end
        if (gprev[i] === 1'b1 && GATED_CLK[i] === 1'b0 && $time - trise[i] < 5) begin
          errors++;
          $display("FAIL runt_pulse ch%0d width %0t required >= 5", i, $time - trise[i]);
        end
        if (GATED_CLK[i] === 1'b1) begin
          trise[i] = $time;
          gcnt[i]++;
        end
      end
    end
    gprev = GATED_CLK;
  end

  // One clock: apply inputs, predict the gated edge from the pre-edge model state, then advance the model.
  task automatic cyc(input logic [N-1:0] e, input logic [N-1:0] d, input logic [N-1:0] a,
                     input logic [N*8-1:0] l, input logic f, input logic t);
    logic [N-1:0] eg, es, er;
    CLK_EN = e; CLK_DIS = d; AUTO_MODE = a; STALL_LEN = l; FORCE_ON = f; TEST_EN = t;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      eg[i] = (rem[i] == 0) || t;
      er[i] = 1'b0;
      if (f || e[i]) rem[i] = 0;
      else if (rem[i] > 0) begin
        if (rem[i] == 1) er[i] = 1'b1;
        rem[i]--;
      end else if (rem[i] == 0 && d[i]) rem[i] = a[i] ? int'(l[i*8 +: 8]) : -1;
      es[i] = rem[i] != 0;
    end
    chk("gated_clk", 32'(GATED_CLK), 32'(eg));
    chk("stalled", 32'(STALLED), 32'(es));
    chk("resumed", 32'(RESUMED), 32'(er));
    chk("all_stalled", 32'(ALL_STALLED), 32'(&es));
  endtask

  task automatic idle(input logic t);
    cyc('0, '0, '0, '0, 1'b0, t);
  endtask

  typedef struct {
    logic [N-1:0] dis, en, auto_m;
    logic [7:0] len;
    logic frc;
    logic [N-1:0] st, rs;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int sc, rc, g2, g3;
    bit did_rst;
    logic [N-1:0] rd, re, ra;
    logic [N*8-1:0] rl;
    tbl[0]  = '{9'h000, 9'h000, 9'h000, 8'd0, 1'b0, 9'h000, 9'h000};
    tbl[1]  = '{9'h004, 9'h000, 9'h000, 8'd0, 1'b0, 9'h004, 9'h000};
    tbl[2]  = '{9'h000, 9'h000, 9'h000, 8'd0, 1'b0, 9'h004, 9'h000};
    tbl[3]  = '{9'h001, 9'h000, 9'h001, 8'd3, 1'b0, 9'h005, 9'h000};
    tbl[4]  = '{9'h000, 9'h000, 9'h000, 8'd0, 1'b0, 9'h005, 9'h000};
    tbl[5]  = '{9'h000, 9'h000, 9'h000, 8'd0, 1'b0, 9'h005, 9'h000};
    tbl[6]  = '{9'h000, 9'h000, 9'h000, 8'd0, 1'b0, 9'h004, 9'h001};
    tbl[7]  = '{9'h004, 9'h004, 9'h000, 8'd0, 1'b0, 9'h000, 9'h000};
    tbl[8]  = '{9'h1FF, 9'h000, 9'h000, 8'd0, 1'b0, 9'h1FF, 9'h000};
    tbl[9]  = '{9'h000, 9'h000, 9'h000, 8'd0, 1'b1, 9'h000, 9'h000};
    tbl[10] = '{9'h002, 9'h000, 9'h002, 8'd0, 1'b0, 9'h000, 9'h000};
    tbl[11] = '{9'h002, 9'h002, 9'h000, 8'd0, 1'b0, 9'h000, 9'h000};
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      gcnt[i] = 0;
    end
    #12;
    chk("reset_stalled", 32'(STALLED), 32'h0);
    chk("reset_resumed", 32'(RESUMED), 32'h0);
    chk("reset_all", 32'(ALL_STALLED), 32'h0);
    #10 rst = 1'b1;
    foreach (tbl[k]) begin
      cyc(tbl[k].en, tbl[k].dis, tbl[k].auto_m, {N{tbl[k].len}}, tbl[k].frc, 1'b0);
      chk($sformatf("tbl%0d_stalled", k), 32'(STALLED), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_resumed", k), 32'(RESUMED), 32'(tbl[k].rs));
      chk($sformatf("tbl%0d_all", k), 32'(ALL_STALLED), 32'(&tbl[k].st));
    end
    // Hold on channel 2 for 19 further cycles, other channels keep running.
    cyc('0, 9'h004, '0, '0, 1'b0, 1'b0);
    g2 = gcnt[2]; g3 = gcnt[3];
    repeat (19) idle(1'b0);
    chk("hold_ch2_edges", 32'(gcnt[2] - g2), 32'd0);
    chk("hold_ch3_edges", 32'(gcnt[3] - g3), 32'd19);
    cyc(9'h004, '0, '0, '0, 1'b0, 1'b0);
    g2 = gcnt[2];
    idle(1'b0);
    chk("hold_resume_edge", 32'(gcnt[2] - g2), 32'd1);
    // Timed stall of 5, then 0 (ignored), then 255 (no wrap).
    g2 = gcnt[0]; sc = 0; rc = 0;
    cyc('0, 9'h001, 9'h001, {N{8'd5}}, 1'b0, 1'b0);
    sc += int'(STALLED[0]);
    repeat (7) begin
      idle(1'b0);
      sc += int'(STALLED[0]); rc += int'(RESUMED[0]);
    end
    chk("timed5_stalled_cycles", 32'(sc), 32'd5);
    chk("timed5_resumed_pulses", 32'(rc), 32'd1);
    chk("timed5_edges", 32'(gcnt[0] - g2), 32'd3);
    cyc('0, 9'h001, 9'h001, '0, 1'b0, 1'b0);
    chk("timed0_ignored", 32'(STALLED[0]), 32'd0);
    sc = 0; rc = 0;
    cyc('0, 9'h001, 9'h001, {N{8'd255}}, 1'b0, 1'b0);
    sc += int'(STALLED[0]);
    repeat (258) begin
      idle(1'b0);
      sc += int'(STALLED[0]); rc += int'(RESUMED[0]);
    end
    chk("timed255_stalled_cycles", 32'(sc), 32'd255);
    chk("timed255_resumed_pulses", 32'(rc), 32'd1);
    // Retrigger ignored, early exit without RESUMED.
    sc = 0; rc = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(c == 6 ? 9'h001 : 9'h000, (c == 0 || c == 3) ? 9'h001 : 9'h000, 9'h001, {N{8'd10}}, 1'b0, 1'b0);
      sc += int'(STALLED[0]); rc += int'(RESUMED[0]);
    end
    chk("retrig_stalled_cycles", 32'(sc), 32'd6);
    chk("retrig_resumed_pulses", 32'(rc), 32'd0);
    // TEST_EN ungates held channels without releasing them.
    cyc('0, 9'h1FF, '0, '0, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    idle(1'b0);
    chk("test_en_hold_kept", 32'(STALLED), 32'h1FF);
    cyc(9'h1FF, '0, '0, '0, 1'b0, 1'b0);
    // Random stimulus with an asynchronous reset while a timed stall is in progress.
    did_rst = 1'b0;
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        rd[i] = ($urandom_range(0, 3) == 0);
        re[i] = ($urandom_range(0, 7) == 0);
        ra[i] = 1'($urandom_range(0, 1));
        rl[i*8 +: 8] = 8'($urandom_range(0, 12));
      end
      cyc(re, rd, ra, rl, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      if (!did_rst && it >= 200) begin
        for (int i = 0; i < N; i++) if (rem[i] > 0) did_rst = 1'b1;
        if (did_rst) begin
          #2 rst = 1'b0;
          #1;
          chk("async_rst_stalled", 32'(STALLED), 32'h0);
          chk("async_rst_resumed", 32'(RESUMED), 32'h0);
          chk("async_rst_all", 32'(ALL_STALLED), 32'h0);
          for (int i = 0; i < N; i++) rem[i] = 0;
          #2 rst = 1'b1;
        end
      end
    end
    chk("async_rst_exercised", 32'(did_rst), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
